// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 4-deep byte FIFO feeding an 8N1-style UART transmitter
// with optional even/odd parity and one or two stop bits.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       ACLK,
  input  logic       ARESET,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  output logic       TX_READY,
  output logic       UART_TXD,
  output logic       BUSY,
  output logic       TX_DONE,
  output logic [2:0] FIFO_LEVEL
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic PAR_INV = (PARITY_ODD != 0);
  localparam logic HAS_PAR = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;

  state_t        state, state_d;
  logic [7:0]    mem [4];
  logic [1:0]    wr_ptr, rd_ptr;
  logic [2:0]    level;
  logic [CW-1:0] baud_cnt, baud_d;
  logic [2:0]    bit_idx, bit_d;
  logic [7:0]    shreg, shreg_d;
  logic          txd_q, txd_d;
  logic          push, pop, bit_end, last_stop;

  assign TX_READY   = (level != 3'd4);
  assign FIFO_LEVEL = level;
  assign UART_TXD   = txd_q;
  assign BUSY       = (state != IDLE) || (level != 3'd0);
  assign push       = TX_VALID && TX_READY;
  assign bit_end    = (baud_cnt == CNT_MAX);
  assign last_stop  = (state == STOP) && bit_end &&
                      (bit_idx == STOP_LAST);
  assign TX_DONE    = last_stop;

  always_comb begin
    state_d = state;
    baud_d  = bit_end ? '0 : baud_cnt + 1'b1;
    bit_d   = bit_idx;
    shreg_d = shreg;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        baud_d = '0;
        if (level != 3'd0) begin
          pop     = 1'b1;
          shreg_d = mem[rd_ptr];
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          bit_d = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            bit_d   = '0;
            state_d = HAS_PAR ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          bit_d   = '0;
        end
      end
      STOP: begin
        if (bit_end) bit_d = bit_idx + 3'd1;
        // back-to-back frames: reload straight into START
        if (last_stop) begin
          bit_d = '0;
          if (level != 3'd0) begin
            pop     = 1'b1;
            shreg_d = mem[rd_ptr];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shreg_d[bit_d];
      PARITY:  txd_d = (^shreg_d) ^ PAR_INV;
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      txd_q    <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_d;
      bit_idx  <= bit_d;
      shreg    <= shreg_d;
      txd_q    <= txd_d;
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   level <= level + 3'd1;
        2'b01:   level <= level - 3'd1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (push) mem[wr_ptr] <= TX_DATA;
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: three configurations driven with directed and random
// traffic, compared every cycle against a frame-schedule reference model.
module tb_uart_tx_serializer;

  localparam int CPB = 4;
  localparam int ND  = 3;
  localparam int MX  = 512;

  logic       aclk = 1'b0;
  logic       areset;
  logic [7:0] tx_data [ND];
  logic       tx_valid[ND];
  logic       tx_ready[ND];
  logic       txd     [ND];
  logic       busy    [ND];
  logic       done    [ND];
  logic [2:0] lvl     [ND];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int         push_e [ND][MX];
  int         start_e[ND][MX];
  logic [7:0] mbyte  [ND][MX];
  int         n      [ND];
  logic [7:0] sendq  [ND][$];

  logic [15:0] cap   [ND];
  int          dn_off[ND];

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc++;

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY_EN(0),
    .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
    .ACLK(aclk), .ARESET(areset), .TX_DATA(tx_data[0]),
    .TX_VALID(tx_valid[0]), .TX_READY(tx_ready[0]),
    .UART_TXD(txd[0]), .BUSY(busy[0]), .TX_DONE(done[0]),
    .FIFO_LEVEL(lvl[0]));

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY_EN(1),
    .PARITY_ODD(0), .STOP_BITS(2)) u_dut1 (
    .ACLK(aclk), .ARESET(areset), .TX_DATA(tx_data[1]),
    .TX_VALID(tx_valid[1]), .TX_READY(tx_ready[1]),
    .UART_TXD(txd[1]), .BUSY(busy[1]), .TX_DONE(done[1]),
    .FIFO_LEVEL(lvl[1]));

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY_EN(1),
    .PARITY_ODD(1), .STOP_BITS(1)) u_dut2 (
    .ACLK(aclk), .ARESET(areset), .TX_DATA(tx_data[2]),
    .TX_VALID(tx_valid[2]), .TX_READY(tx_ready[2]),
    .UART_TXD(txd[2]), .BUSY(busy[2]), .TX_DONE(done[2]),
    .FIFO_LEVEL(lvl[2]));

  function automatic bit pe(int d); return d != 0; endfunction
  function automatic bit po(int d); return d == 2; endfunction
  function automatic int sb(int d); return (d == 1) ? 2 : 1; endfunction
  function automatic int nbits(int d);
    return 9 + int'(pe(d)) + sb(d);
  endfunction
  function automatic int flen(int d); return nbits(d) * CPB; endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // bytes queued after edge t: pushed by t, not yet popped
  function automatic int lvl_at(int d, int t);
    int c = 0;
    for (int k = 0; k < n[d]; k++)
      if (push_e[d][k] <= t && start_e[d][k] > t) c++;
    return c;
  endfunction

  // expected {busy, ready, done, txd, level} after edge t
  function automatic logic [6:0] exp_vec(int d, int t);
    int l;
    logic line, dn, act;
    l = lvl_at(d, t);
    line = 1'b1; dn = 1'b0; act = 1'b0;
    for (int k = 0; k < n[d]; k++) begin
      int off, b;
      off = t - start_e[d][k];
      if (off >= 0 && off < flen(d)) begin
        b = off / CPB;
        act = 1'b1;
        dn = (off == flen(d) - 1);
        if (b == 0) line = 1'b0;
        else if (b <= 8) line = mbyte[d][k][b-1];
        else if (b == 9 && pe(d)) line = (^mbyte[d][k]) ^ po(d);
      end
    end
    return {act || (l != 0), l < 4, dn, line, 3'(l)};
  endfunction

  // frame starts one edge after push, or right when the previous frame ends
  function automatic void accept(int d, int e, logic [7:0] b);
    int s = e + 1;
    if (n[d] > 0 && start_e[d][n[d]-1] + flen(d) > s)
      s = start_e[d][n[d]-1] + flen(d);
    push_e[d][n[d]]  = e;
    start_e[d][n[d]] = s;
    mbyte[d][n[d]]   = b;
    n[d]++;
  endfunction

  function automatic bit idle_all();
    for (int d = 0; d < ND; d++) begin
      if (sendq[d].size() != 0) return 1'b0;
      if (n[d] > 0 && cyc < start_e[d][n[d]-1] + flen(d)) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic drive();
    for (int d = 0; d < ND; d++) begin
      if (sendq[d].size() > 0) begin
        tx_valid[d] = 1'b1;
        tx_data[d]  = sendq[d][0];
        if (lvl_at(d, cyc) < 4 && n[d] < MX) begin
          accept(d, cyc + 1, sendq[d][0]);
          void'(sendq[d].pop_front());
        end
      end else begin
        tx_valid[d] = 1'b0;
        tx_data[d]  = 8'($urandom);
      end
    end
  endtask

  task automatic step();
    @(negedge aclk);
    drive();
  endtask

  task automatic hit_reset();
    areset = 1'b1;
    for (int d = 0; d < ND; d++) begin
      n[d] = 0;
      sendq[d].delete();
      tx_valid[d] = 1'b0;
    end
  endtask

  always @(negedge aclk) begin
    for (int d = 0; d < ND; d++)
      chk($sformatf("cycle_dut%0d", d),
          {busy[d], tx_ready[d], done[d], txd[d], lvl[d]},
          exp_vec(d, cyc));
  end

  initial begin
    int s, guard;
    for (int d = 0; d < ND; d++) begin
      n[d] = 0; tx_valid[d] = 1'b0; tx_data[d] = 8'h00;
    end
    areset = 1'b1;
    repeat (3) @(negedge aclk);
    for (int d = 0; d < ND; d++)
      chk($sformatf("reset_dut%0d", d),
          {busy[d], tx_ready[d], done[d], txd[d], lvl[d]}, 7'b0101000);
    areset = 1'b0;

    // single frames with bit-sample capture
    for (int d = 0; d < ND; d++) begin
      cap[d] = '0;
      dn_off[d] = -1;
      sendq[d].push_back(d == 0 ? 8'hA5 : 8'h07);
    end
    repeat (60) begin
      step();
      for (int d = 0; d < ND; d++) begin
        int off;
        off = cyc - push_e[d][0] - 1;
        if (off >= 0 && off % CPB == 1 && off / CPB < nbits(d))
          cap[d][off / CPB] = txd[d];
        if (done[d] && dn_off[d] < 0) dn_off[d] = off;
      end
    end
    chk("frame_a5", cap[0], 16'h034A);
    chk("frame_07_even_2stop", cap[1], 16'h0E0E);
    chk("frame_07_odd", cap[2], 16'h040E);
    chk("done_pos_a5", dn_off[0], 39);
    chk("done_pos_2stop", dn_off[1], 47);
    chk("done_pos_odd", dn_off[2], 43);

    // held TX_VALID, six bytes back to back
    for (int d = 0; d < ND; d++)
      for (int b = 1; b <= 6; b++) sendq[d].push_back(8'(b));
    repeat (320) step();

    // push landing on the same edge as a pop at level 2
    for (int d = 0; d < ND; d++) begin
      sendq[d].push_back(8'h11);
      sendq[d].push_back(8'h22);
      sendq[d].push_back(8'h33);
    end
    step();
    s = start_e[0][n[0]-1];
    repeat (2) step();
    while (cyc < s + flen(0) - 2) step();
    sendq[0].push_back(8'h44);
    step();
    step();
    chk("push_pop_level", lvl[0], 3'd2);
    repeat (200) step();

    // asynchronous reset during data bit 3
    for (int d = 0; d < ND; d++) sendq[d].push_back(8'hC5);
    for (int d = 0; d < ND; d++) sendq[d].push_back(8'h3C);
    step();
    s = start_e[0][n[0]-1];
    while (cyc < s + 4 * CPB + 1) step();
    @(posedge aclk);
    #2 hit_reset();
    #1;
    for (int d = 0; d < ND; d++)
      chk($sformatf("async_reset_dut%0d", d),
          {busy[d], tx_ready[d], done[d], txd[d], lvl[d]}, 7'b0101000);
    repeat (3) @(negedge aclk);
    @(negedge aclk);
    areset = 1'b0;
    for (int d = 0; d < ND; d++) sendq[d].push_back(8'h55);
    drive();
    @(posedge aclk);
    #1 chk("first_push_after_reset", lvl[0], 3'd1);
    repeat (60) step();

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      for (int d = 0; d < ND; d++)
        if ($urandom_range(0, 39) == 0)
          repeat ($urandom_range(1, 3)) sendq[d].push_back(8'($urandom));
      step();
    end
    guard = 0;
    while (!idle_all() && guard < 8000) begin
      step();
      guard++;
    end
    chk("drain_bound", guard < 8000, 1'b1);
    repeat (5) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
